syn_accum: RTL

- Synaptic accumulation stage that sits directly upstream of the LIF neuron stage.
- For one timestep, it takes the latched pre-synaptic spike vector and walks every post-synaptic neuron in turn.
- For each post neuron it sums the weights of all spiking inputs, read from a weight BRAM, with saturation.
- It presents each neuron's input current on a valid/ready handshake; the LIF stage uses that value as network_input.

---
 rtl/snn_pkg.sv | 10 +
 rtl/sat_add.sv | 14 +
 rtl/syn_accum.sv | 93 +++++++++
 3 files changed

// File: rtl/snn_pkg.sv
// snn_pkg: shared SNN widths, weight/current types, current clamp limits and syn_accum FSM states
package snn_pkg;
  localparam int SNN_WIDTH = 32;
  localparam int SNN_W_WIDTH = 8;
  typedef logic signed [SNN_W_WIDTH-1:0] weight_t;
  typedef logic signed [SNN_WIDTH-1:0] current_t;
  localparam current_t CURRENT_MAX = {1'b0, {(SNN_WIDTH-1){1'b1}}};
  localparam current_t CURRENT_MIN = {1'b1, {(SNN_WIDTH-1){1'b0}}};
  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, EMIT, FIN} syn_state_e;
endpackage

// File: rtl/sat_add.sv
// sat_add: combinational signed saturating adder; ports a, b in, sum out, all WIDTH bits
module sat_add #(
  parameter int WIDTH = 32
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] sum
);
  logic signed [WIDTH-1:0] raw;
  logic ovf;
  assign raw = a + b;
  assign ovf = (a[WIDTH-1] == b[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]);
  assign sum = ovf ? {a[WIDTH-1], {(WIDTH-1){~a[WIDTH-1]}}} : raw;
endmodule

// File: rtl/syn_accum.sv
// syn_accum: per-timestep synaptic weight accumulation; ports clk, rst(async low), start/spk_vec in, w_addr/w_rd_en/w_data BRAM, out_valid/out_ready/out_idx/out_current stream, busy/done status
module syn_accum
  import snn_pkg::*;
#(
  parameter int N_PRE = 64,
  parameter int N_POST = 32,
  parameter int WIDTH = SNN_WIDTH,
  parameter int W_WIDTH = SNN_W_WIDTH,
  localparam int AW = $clog2(N_PRE*N_POST),
  localparam int IW = $clog2(N_POST),
  localparam int PW = $clog2(N_PRE)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [N_PRE-1:0]        spk_vec,
  output logic [AW-1:0]           w_addr,
  output logic                    w_rd_en,
  input  logic signed [W_WIDTH-1:0] w_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [IW-1:0]           out_idx,
  output logic signed [WIDTH-1:0] out_current,
  output logic                    busy,
  output logic                    done
);
  syn_state_e state, nxt;
  logic [N_PRE-1:0] spk_latch;
  logic [PW-1:0] pre;
  logic [IW-1:0] post;
  logic signed [WIDTH-1:0] acc, acc_sum;
  logic rd_q, last_pre, last_post;
  assign last_pre = pre == PW'(N_PRE-1);
  assign last_post = post == IW'(N_POST-1);
  assign w_addr = state == FETCH ? AW'(post) * AW'(N_PRE) + AW'(pre) : '0;
  assign busy = state inside {FETCH, DRAIN, EMIT};
  assign out_idx = post;
  assign out_current = acc;
  sat_add #(.WIDTH(WIDTH)) u_sat (
    .a(acc),
    .b({{(WIDTH-W_WIDTH){w_data[W_WIDTH-1]}}, w_data}),
    .sum(acc_sum)
  );
  always_comb begin
    nxt = state;
    w_rd_en = 1'b0;
    out_valid = 1'b0;
    done = 1'b0;
    case (state)
      IDLE: nxt = start ? FETCH : IDLE;
      FETCH: begin
        w_rd_en = spk_latch[pre];
        nxt = last_pre ? DRAIN : FETCH;
      end
      DRAIN: nxt = EMIT;
      EMIT: begin
        out_valid = 1'b1;
        nxt = out_ready ? (last_post ? FIN : FETCH) : EMIT;
      end
      FIN: begin
        done = 1'b1;
        nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      spk_latch <= '0;
      pre <= '0;
      post <= '0;
      acc <= '0;
      rd_q <= 1'b0;
    end else begin
      state <= nxt;
      rd_q <= w_rd_en;
      if (state == IDLE && start) begin
        spk_latch <= spk_vec;
        pre <= '0;
        post <= '0;
        acc <= '0;
      end
      if (state == FETCH) pre <= last_pre ? '0 : pre + 1'b1;
      // rd_q marks the cycle the BRAM word requested last cycle is on w_data
      if (rd_q) acc <= acc_sum;
      if (state == EMIT && out_ready) begin
        post <= last_post ? post : post + 1'b1;
        acc <= last_post ? acc : '0;
      end
    end
  end
endmodule
